// File: rtl/pam4_pkg.sv
// pam4_pkg: shared types and helpers for the PAM4 transmit mapper.
//   state_e      : mapper FSM state (IDLE / SEND)
//   LVLx_DEF     : default voltage levels for Gray symbols 00, 01, 11, 10
//   gray_map     : 2-bit natural value -> 8-bit voltage level
//   prbs7_step8  : advances a PRBS7 (x^7+x^6+1) state by 8 bits
package pam4_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [7:0] LVL0_DEF = 8'h1C;
  localparam logic [7:0] LVL1_DEF = 8'h54;
  localparam logic [7:0] LVL2_DEF = 8'hAC;
  localparam logic [7:0] LVL3_DEF = 8'hE4;

  typedef struct packed {
    logic [6:0] state;
    logic [7:0] data;
  } prbs_step_t;

  // Gray order of the four levels is 00, 01, 11, 10 from lowest to highest,
  // so natural value 10 maps to the top level and 11 to the third.
  function automatic logic [7:0] gray_map(input logic [1:0] v,
                                          input logic [7:0] l0,
                                          input logic [7:0] l1,
                                          input logic [7:0] l2,
                                          input logic [7:0] l3);
    logic [7:0] lvl;
    case (v)
      2'b00:   lvl = l0;
      2'b01:   lvl = l1;
      2'b11:   lvl = l2;
      default: lvl = l3;
    endcase
    return lvl;
  endfunction

  // First generated bit lands in data[0].
  function automatic prbs_step_t prbs7_step8(input logic [6:0] s_in);
    prbs_step_t r;
    logic [6:0] s;
    logic       nb;
    s = s_in;
    r.data = '0;
    for (int i = 0; i < 8; i++) begin
      nb = s[6] ^ s[5];
      s = {s[5:0], nb};
      r.data[i] = nb;
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/pam4_tx_prbs7_gen.sv
// prbs7_gen: PRBS7 byte source for link bring-up.
//   clk, rst   : clock, asynchronous active-high reset (state -> 7'h7F)
//   advance_i  : consume the current byte and step the state by 8 bits
//   byte_o     : next 8 PRBS bits, first generated bit in bit 0
module prbs7_gen
  import pam4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance_i,
  output logic [7:0] byte_o
);

  logic [6:0] state_q;
  prbs_step_t step;

  assign step   = prbs7_step8(state_q);
  assign byte_o = step.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state_q <= 7'h7F;
    else if (advance_i) state_q <= step.state;
  end

endmodule

// File: rtl/pam4_tx.sv
// pam4_tx: PAM4 transmit mapper. Bytes arrive on a valid/ready handshake
// (or from the internal PRBS7 source) and are sent as four Gray-mapped
// 2-bit symbols, LSB pair first, one every SYM_PERIOD clocks.
//   clk, rst          : clock, asynchronous active-high reset
//   data_in/_valid    : byte to send / byte valid
//   data_in_ready     : byte taken on an edge where valid & ready
//   prbs_en           : 1 = PRBS7 source replaces data_in
//   signal_out        : voltage level, held between symbols
//   signal_out_valid  : one-cycle strobe per new symbol
//   busy              : high while in SEND
module pam4_tx
  import pam4_pkg::*;
#(
  parameter int         SYM_PERIOD = 2,
  parameter logic [7:0] LVL0       = LVL0_DEF,
  parameter logic [7:0] LVL1       = LVL1_DEF,
  parameter logic [7:0] LVL2       = LVL2_DEF,
  parameter logic [7:0] LVL3       = LVL3_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  input  logic       prbs_en,
  output logic [7:0] signal_out,
  output logic       signal_out_valid,
  output logic       busy
);

  localparam int            CW       = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_PERIOD - 1);

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sym_idx_q, sym_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic       can_load;
  logic       at_boundary;
  logic       load_ext;
  logic       load_prbs;
  logic [7:0] prbs_byte;

  // Last clock of the last symbol of a byte: a new byte loaded here keeps
  // the symbol stream gapless.
  assign at_boundary = (state_q == SEND) && (sym_idx_q == 2'd3) && (cnt_q == CNT_LAST);
  assign can_load    = (state_q == IDLE) || at_boundary;
  // Ready is combinational, so it is forced low while reset is asserted.
  assign data_in_ready = ~rst & ~prbs_en & can_load;
  assign load_ext      = data_in_ready & data_in_valid;
  assign load_prbs     = prbs_en & can_load;

  prbs7_gen u_prbs (
    .clk       (clk),
    .rst       (rst),
    .advance_i (load_prbs),
    .byte_o    (prbs_byte)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sym_idx_d   = sym_idx_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (state_q == SEND) begin
      if (cnt_q == '0) begin
        out_d       = gray_map(shift_q[{sym_idx_q, 1'b0} +: 2], LVL0, LVL1, LVL2, LVL3);
        out_valid_d = 1'b1;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        sym_idx_d = sym_idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (at_boundary) state_d = IDLE;
    end

    // A load overrides the boundary return to IDLE.
    if (load_ext || load_prbs) begin
      shift_d   = load_prbs ? prbs_byte : data_in;
      cnt_d     = '0;
      sym_idx_d = 2'd0;
      state_d   = SEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      sym_idx_q   <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sym_idx_q   <= sym_idx_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign signal_out       = out_q;
  assign signal_out_valid = out_valid_q;
  assign busy             = (state_q == SEND);

endmodule

// File: tb/tb_pam4_tx.sv
// Bench for pam4_tx: one instance with SYM_PERIOD=2, one with SYM_PERIOD=1.
// Expected strobes, levels, ready and busy are derived arithmetically from
// the accept edge of the first byte of each stream.
module tb_pam4_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din   [2];
  logic       din_v [2];
  logic       prbs  [2];
  logic [7:0] so    [2];
  logic       sov   [2];
  logic       rdy   [2];
  logic       bsy   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] lvl_tbl [4] = '{8'h1C, 8'h54, 8'hE4, 8'hAC};  // index = 2-bit value
  logic [7:0] last_lvl [2] = '{8'h00, 8'h00};
  logic [6:0] prbs_s   [2] = '{7'h7F, 7'h7F};
  logic [7:0] stim [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pam4_tx #(.SYM_PERIOD(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_in_valid(din_v[0]),
    .data_in_ready(rdy[0]), .prbs_en(prbs[0]), .signal_out(so[0]),
    .signal_out_valid(sov[0]), .busy(bsy[0]));

  pam4_tx #(.SYM_PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_in_valid(din_v[1]),
    .data_in_ready(rdy[1]), .prbs_en(prbs[1]), .signal_out(so[1]),
    .signal_out_valid(sov[1]), .busy(bsy[1]));

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Bit-serial PRBS7 reference: nb = s6^s5, shifted in at the bottom.
  task automatic fill_prbs(input int sel, input int n);
    logic nb;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        nb = prbs_s[sel][6] ^ prbs_s[sel][5];
        prbs_s[sel] = {prbs_s[sel][5:0], nb};
        stim[i][b] = nb;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk8({tag, "_out"}, so[i], 8'h00);
      chk1({tag, "_valid"}, sov[i], 1'b0);
      chk1({tag, "_ready"}, rdy[i], 1'b0);
      chk1({tag, "_busy"}, bsy[i], 1'b0);
    end
  endtask

  // Sends stim[0..n-1] (or n PRBS bytes) back to back starting from IDLE.
  // Must be entered just after a rising edge.
  task automatic run_stream(input int sel, input bit pm, input int n, input string tag);
    int sp, per, e0, d, t, s, dn;
    logic [7:0] b;
    logic ev, er;
    sp  = (sel == 0) ? 2 : 1;
    per = 4 * sp;
    e0  = cyc + 1;
    if (pm) prbs[sel] = 1'b1;
    else begin
      din_v[sel] = 1'b1;
      din[sel]   = stim[0];
    end
    for (int c = e0 - 1; c <= e0 + per * n + 3; c++) begin
      @(negedge clk);
      t = c - e0 - 1;   // offset of last edge from first strobe edge
      d = c + 1 - e0;   // offset of upcoming edge from first load edge
      ev = 1'b0;
      if (t >= 0 && (t % sp) == 0 && (t / sp) < 4 * n) begin
        s  = t / sp;
        b  = stim[s / 4];
        last_lvl[sel] = lvl_tbl[(b >> (2 * (s % 4))) & 8'd3];
        ev = 1'b1;
      end
      if (pm) er = (d >= per * n);
      else    er = ((d % per) == 0) || (d > per * n);
      chk1({tag, "_valid"}, sov[sel], ev);
      chk8({tag, "_level"}, so[sel], last_lvl[sel]);
      chk1({tag, "_ready"}, rdy[sel], er);
      chk1({tag, "_busy"}, bsy[sel], (c >= e0) && (c < e0 + per * n));
      @(posedge clk);
      #1;
      dn = d + 1;
      if (pm) begin
        if (d == per * (n - 1)) prbs[sel] = 1'b0;
      end else if (dn < per * n && (dn % per) == 0) begin
        din_v[sel] = 1'b1;
        din[sel]   = stim[dn / per];
      end else if (dn < per * n) begin
        // Not ready here: garbage must be ignored.
        din_v[sel] = 1'($urandom);
        din[sel]   = 8'($urandom);
      end else begin
        din_v[sel] = 1'b0;
      end
    end
    $display("stream %s: sel=%0d prbs=%0d bytes=%0d first=%h errors=%0d", tag, sel, pm, n, stim[0], errors);
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; din_v[i] = 1'b0; prbs[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1("idle_ready", rdy[i], 1'b1);
        chk1("idle_valid", sov[i], 1'b0);
        chk8("idle_out", so[i], 8'h00);
        chk1("idle_busy", bsy[i], 1'b0);
      end
    end
    @(posedge clk); #1;

    stim[0] = 8'hE4;
    run_stream(0, 1'b0, 1, "single_E4");
    stim[0] = 8'hE4; stim[1] = 8'h1B;
    run_stream(0, 1'b0, 2, "b2b_E4_1B");
    for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
    run_stream(0, 1'b0, 6, "rand_sp2");

    stim[0] = 8'h00; stim[1] = 8'hFF;
    run_stream(1, 1'b0, 2, "sp1_00_FF");
    for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
    run_stream(1, 1'b0, 5, "rand_sp1");

    fill_prbs(0, 130);
    run_stream(0, 1'b1, 130, "prbs_sp2");
    fill_prbs(1, 10);
    run_stream(1, 1'b1, 10, "prbs_sp1");

    // Reset in the middle of a byte (while symbol 2 is on the line).
    din_v[0] = 1'b1; din[0] = 8'hA5;
    e0 = cyc + 1;
    @(posedge clk); #1;
    din_v[0] = 1'b0;
    while (cyc < e0 + 5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("mid_valid", sov[0], 1'b1);
    chk8("mid_level", so[0], 8'hE4);
    chk1("mid_busy", bsy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    $display("mid-byte reset applied at cycle %0d", cyc);
    @(posedge clk); #1;
    rst = 1'b0;
    last_lvl[0] = 8'h00; last_lvl[1] = 8'h00;
    prbs_s[0] = 7'h7F;   prbs_s[1] = 7'h7F;

    stim[0] = 8'h36; stim[1] = 8'($urandom);
    run_stream(0, 1'b0, 2, "after_rst");
    fill_prbs(0, 3);
    run_stream(0, 1'b1, 3, "prbs_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
